// File: rtl/mixer_multich_if.sv
// ---------------------------------------------------------------------------
// mixer_multich_if
// Groups the mixer's sample/volume/1-bit source inputs and its level, clip,
// strobe and DAC outputs into one bundle.
//   master : drives ch_l, ch_r, vol, beeper, tape_out, tape_in, mute;
//            observes level_l/r, clip_l/r, sample_strobe, dac_l/r
//   slave  : the mixer itself (opposite directions)
// ---------------------------------------------------------------------------
interface mixer_multich_if #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 8,
    parameter int VOL_W    = 4,
    parameter int DAC_W    = 10
);
    logic [CHANNELS*SAMPLE_W-1:0] ch_l;
    logic [CHANNELS*SAMPLE_W-1:0] ch_r;
    logic [CHANNELS*VOL_W-1:0]    vol;
    logic                         beeper;
    logic                         tape_out;
    logic                         tape_in;
    logic                         mute;
    logic [DAC_W-1:0]             level_l;
    logic [DAC_W-1:0]             level_r;
    logic                         clip_l;
    logic                         clip_r;
    logic                         sample_strobe;
    logic                         dac_l;
    logic                         dac_r;

    modport master (
        output ch_l, ch_r, vol, beeper, tape_out, tape_in, mute,
        input  level_l, level_r, clip_l, clip_r, sample_strobe, dac_l, dac_r
    );

    modport slave (
        input  ch_l, ch_r, vol, beeper, tape_out, tape_in, mute,
        output level_l, level_r, clip_l, clip_r, sample_strobe, dac_l, dac_r
    );
endinterface

// File: rtl/mixer_multich.sv
// ---------------------------------------------------------------------------
// mixer_multich
// Time-multiplexed stereo mixer for CHANNELS unsigned PCM channel pairs with
// per-channel volume, plus beeper / tape_out / tape_in contributions, driving
// two first-order sigma-delta DAC bits.
//
// One channel is accumulated per clk28 cycle (slots 0..CHANNELS-1); in slot
// CHANNELS the 1-bit sources are added, the result is saturated to DAC_W bits
// and latched with a one-cycle sample_strobe. Frame length is CHANNELS+1.
//
// Ports:
//   i_clk28 : system clock (28 MHz)
//   i_rst   : synchronous reset, active-high
//   io_mix  : mixer_multich_if.slave (samples, volumes, 1-bit sources, mute
//             in; latched levels, clip flags, strobe, DAC bits out)
// ---------------------------------------------------------------------------
module mixer_multich #(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_W     = 8,
    parameter int VOL_W        = 4,
    parameter int DAC_W        = 10,
    parameter int BEEP_LVL     = 128,
    parameter int TAPE_OUT_LVL = 32,
    parameter int TAPE_IN_LVL  = 16
) (
    input  logic             i_clk28,
    input  logic             i_rst,
    mixer_multich_if.slave   io_mix
);

    localparam int SUM_W  = SAMPLE_W + $clog2(CHANNELS) + 2;
    localparam int SLOT_W = (CHANNELS < 2) ? 1 : $clog2(CHANNELS + 1);
    localparam int PROD_W = SAMPLE_W + VOL_W;
    localparam int BIT_W  = $clog2(BEEP_LVL + TAPE_OUT_LVL + TAPE_IN_LVL + 1);
    // Final sum width: wide enough for the accumulator, the 1-bit sources and
    // the saturation threshold, plus a carry bit.
    localparam int MAX_W  = (SUM_W > BIT_W) ? ((SUM_W > DAC_W) ? SUM_W : DAC_W)
                                            : ((BIT_W > DAC_W) ? BIT_W : DAC_W);
    localparam int TOT_W  = MAX_W + 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS);
    localparam logic [TOT_W-1:0]  LVL_MAX   = TOT_W'({DAC_W{1'b1}});

    logic [SLOT_W-1:0]   r_slot;
    logic [SUM_W-1:0]    r_acc_l;
    logic [SUM_W-1:0]    r_acc_r;
    logic [DAC_W-1:0]    r_level_l;
    logic [DAC_W-1:0]    r_level_r;
    logic                r_clip_l;
    logic                r_clip_r;
    logic                r_strobe;
    logic [DAC_W:0]      r_sd_l;
    logic [DAC_W:0]      r_sd_r;

    logic [SAMPLE_W-1:0] w_smp_l;
    logic [SAMPLE_W-1:0] w_smp_r;
    logic [VOL_W-1:0]    w_vol;
    logic [SAMPLE_W-1:0] w_term_l;
    logic [SAMPLE_W-1:0] w_term_r;
    logic                w_last;
    logic [TOT_W-1:0]    w_bits;
    logic [TOT_W-1:0]    w_sum_l;
    logic [TOT_W-1:0]    w_sum_r;
    logic                w_over_l;
    logic                w_over_r;
    logic [DAC_W-1:0]    w_lvl_l;
    logic [DAC_W-1:0]    w_lvl_r;

    // Full-scale volume passes the sample unchanged; otherwise sample*vol/2^VOL_W.
    function automatic logic [SAMPLE_W-1:0] scale(input logic [SAMPLE_W-1:0] smp,
                                                  input logic [VOL_W-1:0]    v);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(smp) * PROD_W'(v);
        if (v == {VOL_W{1'b1}})
            return smp;
        return prod[PROD_W-1:VOL_W];
    endfunction

    // Channel select for the current slot; the latch slot selects nothing.
    always_comb begin
        w_smp_l = '0;
        w_smp_r = '0;
        w_vol   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_slot == SLOT_W'(k)) begin
                w_smp_l = io_mix.ch_l[k*SAMPLE_W +: SAMPLE_W];
                w_smp_r = io_mix.ch_r[k*SAMPLE_W +: SAMPLE_W];
                w_vol   = io_mix.vol[k*VOL_W +: VOL_W];
            end
        end
    end

    assign w_term_l = scale(w_smp_l, w_vol);
    assign w_term_r = scale(w_smp_r, w_vol);
    assign w_last   = (r_slot == LAST_SLOT);

    assign w_bits = (io_mix.beeper   ? TOT_W'(BEEP_LVL)     : '0)
                  + (io_mix.tape_out ? TOT_W'(TAPE_OUT_LVL) : '0)
                  + (io_mix.tape_in  ? TOT_W'(TAPE_IN_LVL)  : '0);

    assign w_sum_l  = TOT_W'(r_acc_l) + w_bits;
    assign w_sum_r  = TOT_W'(r_acc_r) + w_bits;
    assign w_over_l = (w_sum_l > LVL_MAX);
    assign w_over_r = (w_sum_r > LVL_MAX);

    always_comb begin
        w_lvl_l = '0;
        w_lvl_r = '0;
        if (!io_mix.mute) begin
            w_lvl_l = w_over_l ? {DAC_W{1'b1}} : w_sum_l[DAC_W-1:0];
            w_lvl_r = w_over_r ? {DAC_W{1'b1}} : w_sum_r[DAC_W-1:0];
        end
    end

    always_ff @(posedge i_clk28) begin
        if (i_rst) begin
            r_slot    <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_level_l <= '0;
            r_level_r <= '0;
            r_clip_l  <= 1'b0;
            r_clip_r  <= 1'b0;
            r_strobe  <= 1'b0;
            r_sd_l    <= '0;
            r_sd_r    <= '0;
        end else begin
            r_strobe <= w_last;
            if (w_last) begin
                r_slot    <= '0;
                r_acc_l   <= '0;
                r_acc_r   <= '0;
                r_level_l <= w_lvl_l;
                r_level_r <= w_lvl_r;
                r_clip_l  <= !io_mix.mute && w_over_l;
                r_clip_r  <= !io_mix.mute && w_over_r;
            end else begin
                r_slot  <= r_slot + 1'b1;
                r_acc_l <= r_acc_l + SUM_W'(w_term_l);
                r_acc_r <= r_acc_r + SUM_W'(w_term_r);
            end
            // First-order sigma-delta: the carry out of the DAC_W-bit phase
            // accumulator is the output bit, so ones-density equals level/2^DAC_W.
            r_sd_l <= {1'b0, r_sd_l[DAC_W-1:0]} + {1'b0, r_level_l};
            r_sd_r <= {1'b0, r_sd_r[DAC_W-1:0]} + {1'b0, r_level_r};
        end
    end

    assign io_mix.level_l       = r_level_l;
    assign io_mix.level_r       = r_level_r;
    assign io_mix.clip_l        = r_clip_l;
    assign io_mix.clip_r        = r_clip_r;
    assign io_mix.sample_strobe = r_strobe;
    assign io_mix.dac_l         = r_sd_l[DAC_W];
    assign io_mix.dac_r         = r_sd_r[DAC_W];

endmodule
